// File: rtl/btn_start_stop_pkg.sv
// Shared types and defaults for the start/stop push-button input stage.
// Debounce FSM state encoding plus default debounce timing constants.
package btn_start_stop_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE         = 2'd0,
        BTN_PRESS_WAIT   = 2'd1,
        BTN_PRESSED      = 2'd2,
        BTN_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned BTN_DEBOUNCE_CYCLES = 200000;
    localparam int unsigned BTN_CNT_W           = 18;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, debounce FSM and counter, press request and held level.
// Extra state taps for the start auto-repeat exist only with BTN_START_AUTOREPEAT_EN.
module btn_debounce
    import btn_start_stop_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = BTN_CNT_W,
    parameter logic        PRESS_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press_nxt,
`ifdef BTN_START_AUTOREPEAT_EN
    output logic o_in_pressed,
    output logic o_pressed_nxt,
`endif
    output logic o_held
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_s;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= ~PRESS_LEVEL;
            r_sync2 <= ~PRESS_LEVEL;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = (r_sync2 == PRESS_LEVEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BTN_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else begin
            case (r_state)
                BTN_IDLE: begin
                    if (w_s) begin
                        r_state <= BTN_PRESS_WAIT;
                        r_cnt   <= LOAD;
                    end
                end
                BTN_PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= BTN_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= BTN_PRESSED;
                        r_held  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - ONE;
                    end
                end
                BTN_PRESSED: begin
                    if (!w_s) begin
                        r_state <= BTN_RELEASE_WAIT;
                        r_cnt   <= LOAD;
                    end
                end
                BTN_RELEASE_WAIT: begin
                    if (w_s) begin
                        r_state <= BTN_PRESSED;
                    end else if (r_cnt == '0) begin
                        r_state <= BTN_IDLE;
                        r_held  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - ONE;
                    end
                end
                default: begin
                    r_state <= BTN_IDLE;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    // High in the cycle whose closing edge accepts the press, so the top can register it.
    assign o_press_nxt = (r_state == BTN_PRESS_WAIT) && w_s && (r_cnt == '0);
    assign o_held      = r_held;

`ifdef BTN_START_AUTOREPEAT_EN
    assign o_in_pressed  = (r_state == BTN_PRESSED);
    assign o_pressed_nxt = w_s && ((r_state == BTN_PRESSED) ||
                                   (r_state == BTN_RELEASE_WAIT) || o_press_nxt);
`endif

endmodule

// File: rtl/btn_start_stop.sv
// Start/stop button front end: two debouncers plus stop-priority arbitration.
// Optional start auto-repeat enabled by defining BTN_START_AUTOREPEAT_EN.
module btn_start_stop
    import btn_start_stop_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = BTN_CNT_W,
    parameter logic        PRESS_LEVEL     = 1'b0,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_start,
    input  logic i_btn_stop,
    output logic o_start,
    output logic o_stop,
    output logic o_start_held,
    output logic o_stop_held
);

    logic w_start_press;
    logic w_stop_press;
    logic w_start_held;
    logic w_stop_held;
    logic w_start_req;

`ifdef BTN_START_AUTOREPEAT_EN
    localparam int unsigned      RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);

    logic             w_start_in_pressed;
    logic             w_start_pressed_nxt;
    logic             w_rpt;
    logic [RPT_W-1:0] r_rpt_cnt;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .PRESS_LEVEL     (PRESS_LEVEL)
    ) u_start (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn         (i_btn_start),
        .o_press_nxt   (w_start_press),
`ifdef BTN_START_AUTOREPEAT_EN
        .o_in_pressed  (w_start_in_pressed),
        .o_pressed_nxt (w_start_pressed_nxt),
`endif
        .o_held        (w_start_held)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .PRESS_LEVEL     (PRESS_LEVEL)
    ) u_stop (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn         (i_btn_stop),
        .o_press_nxt   (w_stop_press),
`ifdef BTN_START_AUTOREPEAT_EN
        .o_in_pressed  (),
        .o_pressed_nxt (),
`endif
        .o_held        (w_stop_held)
    );

`ifdef BTN_START_AUTOREPEAT_EN
    // Reload on entry to PRESSED and after each repeat; cleared whenever PRESSED is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt <= '0;
        end else if (!w_start_pressed_nxt) begin
            r_rpt_cnt <= '0;
        end else if (!w_start_in_pressed || (r_rpt_cnt == '0)) begin
            r_rpt_cnt <= RPT_LOAD;
        end else begin
            r_rpt_cnt <= r_rpt_cnt - RPT_ONE;
        end
    end

    assign w_rpt       = w_start_in_pressed && w_start_pressed_nxt && (r_rpt_cnt == '0);
    assign w_start_req = w_start_press | w_rpt;
`else
    assign w_start_req = w_start_press;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_start <= 1'b0;
            o_stop  <= 1'b0;
        end else begin
            o_stop  <= w_stop_press;
            o_start <= w_start_req & ~w_stop_press & ~w_stop_held;
        end
    end

    assign o_start_held = w_start_held;
    assign o_stop_held  = w_stop_held;

endmodule

// File: tb/tb_btn_start_stop.sv
// Randomized + directed scoreboard bench for btn_start_stop (DEBOUNCE_CYCLES=4, active-low pins).
module tb_btn_start_stop;

    localparam int unsigned D = 4;
    localparam int unsigned R = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_btn_start = 1'b1;
    logic i_btn_stop = 1'b1;
    logic o_start, o_stop, o_start_held, o_stop_held;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int last_start_edge = -1;
    int start_pulses = 0;

    logic [3:0] exp_q[$];

    // Reference model: per button a 2-sample pipeline of raw "pressed" values, the accepted
    // level, and the length of the current run of samples disagreeing with that level.
    bit p1[2], p2[2], mheld[2];
    int run[2];
    bit was_pressed;
    int rk;

    btn_start_stop #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8),
        .PRESS_LEVEL     (1'b0),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_btn_start  (i_btn_start),
        .i_btn_stop   (i_btn_stop),
        .o_start      (o_start),
        .o_stop       (o_stop),
        .o_start_held (o_start_held),
        .o_stop_held  (o_stop_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            p1[i] = 1'b0; p2[i] = 1'b0; mheld[i] = 1'b0; run[i] = 0;
        end
        was_pressed = 1'b0;
        rk = 0;
    endtask

    task automatic model_step(input bit sp, input bit tp, input bit rst);
        bit raw[2];
        bit pulse[2];
        bit s, stop_held_prev, rpt, now_pressed, exp_start;
        if (rst) begin
            model_reset();
            exp_q.push_back(4'b0000);
            return;
        end
        raw[0] = sp; raw[1] = tp;
        stop_held_prev = mheld[1];
        rpt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s = p2[i];
            p2[i] = p1[i];
            p1[i] = raw[i];
            pulse[i] = 1'b0;
            if (s != mheld[i]) begin
                run[i]++;
                if (run[i] == int'(D) + 1) begin
                    mheld[i] = ~mheld[i];
                    run[i] = 0;
                    pulse[i] = mheld[i];
                end
            end else begin
                run[i] = 0;
            end
        end
`ifdef BTN_START_AUTOREPEAT_EN
        now_pressed = mheld[0] && (run[0] == 0);
        if (now_pressed && was_pressed) begin
            rk++;
            if (rk == int'(R)) begin
                rpt = 1'b1;
                rk = 0;
            end
        end else begin
            rk = 0;
        end
        was_pressed = now_pressed;
`else
        now_pressed = 1'b0;
        was_pressed = now_pressed;
`endif
        exp_start = (pulse[0] | rpt) & ~pulse[1] & ~stop_held_prev;
        exp_q.push_back({exp_start, pulse[1], mheld[0], mheld[1]});
    endtask

    // One clock of stimulus: pins are "pressed" flags, converted to active-low pin levels.
    task automatic cyc(input bit sp, input bit tp, input bit rst_low);
        @(negedge clk);
        i_btn_start = ~sp;
        i_btn_stop  = ~tp;
        rst_n       = ~rst_low;
        #1;
        if (rst_low) begin
            checks++;
            if ({o_start, o_stop, o_start_held, o_stop_held} != 4'b0000) begin
                errors++;
                $display("FAIL async_reset: outputs=%b required=0000",
                         {o_start, o_stop, o_start_held, o_stop_held});
            end
        end
        model_step(sp, tp, rst_low);
    endtask

    task automatic hold(input bit sp, input bit tp, input int n);
        for (int i = 0; i < n; i++) cyc(sp, tp, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle; compare against the queued expectation.
    initial begin
        logic [3:0] got, exp;
        forever begin
            @(posedge clk);
            #1;
            got = {o_start, o_stop, o_start_held, o_stop_held};
            if (o_start) begin
                last_start_edge = edge_cnt;
                start_pulses++;
            end
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL outputs@edge%0d: got start,stop,sheld,pheld=%b required=%b",
                             edge_cnt, got, exp);
                end
            end
        end
    end

    initial begin
        int e0, p0, wait_cnt;
        bit sp, tp;
        model_reset();
        hold(1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
        hold(1'b0, 1'b0, 3);

        // Single clean start press: pulse expected 6 edges after the first pressed sample.
        @(negedge clk);
        e0 = edge_cnt + 1;
        p0 = start_pulses;
        i_btn_start = 1'b0;
        #1 model_step(1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 49);
        hold(1'b0, 1'b0, 15);
        checks++;
        if (last_start_edge - e0 != int'(D) + 2) begin
            errors++;
            $display("FAIL press_latency: got %0d edges required %0d", last_start_edge - e0, D + 2);
        end
`ifndef BTN_START_AUTOREPEAT_EN
        checks++;
        if (start_pulses - p0 != 1) begin
            errors++;
            $display("FAIL pulse_count: got %0d pulses required 1", start_pulses - p0);
        end
`endif

        // Bounce: 3 pressed, 1 released, ten times.
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, 1'b0, 3);
            hold(1'b0, 1'b0, 1);
        end
        hold(1'b0, 1'b0, 10);

        // Simultaneous press, then start pressed while stop still held.
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b0, 15);

        // Reset pulsed while start is held.
        hold(1'b1, 1'b0, 20);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        hold(1'b1, 1'b0, 20);

        // Release bounce while pressed.
        hold(1'b0, 1'b0, 2);
        hold(1'b1, 1'b0, 15);
        hold(1'b0, 1'b0, 15);

        // Random segments of varying length on both pins.
        for (int seg = 0; seg < 60; seg++) begin
            sp = ($urandom_range(0, 2) != 0);
            tp = ($urandom_range(0, 3) == 0);
            hold(sp, tp, $urandom_range(1, 12));
        end
        hold(1'b0, 1'b0, 15);

`ifdef BTN_START_AUTOREPEAT_EN
        hold(1'b1, 1'b0, 40);
        hold(1'b0, 1'b0, 15);
`endif

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
